// File: rtl/seq_det_sched_pkg.sv
// Shared types and constants for the detector scheduler.
// Optional round-robin arbitration is enabled by defining SEQ_DET_SCHED_RR_EN.
package seq_det_sched_pkg;

  typedef enum logic [2:0] {IDLE, GRANT, SHIFT, DRAIN, DONE} state_e;

  localparam int N_DEF = 4;
  localparam int W_DEF = 8;

  // Hit-count width: enough to hold W detections.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_det_sched_if.sv
// Requester bus plus detector pins of the scheduler.
// The master side is the requesters and the detector; the slave side is the scheduler.
interface seq_det_sched_if
  import seq_det_sched_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
);
  localparam int CW = cnt_w(W);

  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [CW-1:0]  hit_cnt;
  logic           busy;
  logic           det_a;
  logic           det_rst;
  logic           det_q;

  modport master (
    output req, req_data, det_q,
    input  gnt, done, hit_cnt, busy, det_a, det_rst
  );

  modport slave (
    input  req, req_data, det_q,
    output gnt, done, hit_cnt, busy, det_a, det_rst
  );
endinterface

// File: rtl/seq_det_rr_arb.sv
// Combinational rotating-priority arbiter: scans from ptr upward mod N.
// With ptr held at 0 it degenerates to lowest-index-first fixed priority.
module seq_det_rr_arb #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 en,
  output logic [N-1:0]         win
);
  logic [N-1:0] pick;
  logic         found;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(int'(ptr) + i) % N]) begin
        pick[(int'(ptr) + i) % N] = 1'b1;
        found = 1'b1;
      end
    end
  end

  assign win = en ? pick : '0;
endmodule

// File: rtl/seq_det_sched.sv
// Arbitrates N frame requesters onto one serial Moore detector and returns hit counts.
// SEQ_DET_SCHED_RR_EN builds the rotating pointer; otherwise lowest index wins.
module seq_det_sched
  import seq_det_sched_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  seq_det_sched_if.slave bus
);
  localparam int CW = cnt_w(W);
  localparam int KW = $clog2(W);
  localparam int PW = $clog2(N);

  state_e         state, state_nxt;
  logic [N-1:0]   owner, win;
  logic [W-1:0]   frame, sel_data;
  logic [KW-1:0]  k;
  logic [CW-1:0]  cnt, hit_q;
  logic [PW-1:0]  ptr;
  logic           sample;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  seq_det_rr_arb #(.N(N)) u_arb (
    .req (bus.req),
    .ptr (ptr),
    .en  (state == IDLE),
    .win (win)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++)
      if (win[i]) sel_data = sel_data | bus.req_data[i*W +: W];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|win) state_nxt = GRANT;
      GRANT:   state_nxt = SHIFT;
      SHIFT:   if (k == KW'(W - 1)) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // q lags det_a by one cycle, so the k=0 sample is skipped and DRAIN catches the last bit.
  assign sample = bus.det_q && ((state == SHIFT && k != '0) || state == DRAIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      frame <= '0;
      k     <= '0;
      cnt   <= '0;
      hit_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (|win) begin
          owner <= win;
          frame <= sel_data;
        end
        GRANT: begin
          k   <= '0;
          cnt <= '0;
        end
        SHIFT: begin
          frame <= frame << 1;
          k     <= k + KW'(1);
          if (sample) cnt <= sat_inc(cnt);
        end
        DRAIN: hit_q <= sample ? sat_inc(cnt) : cnt;
        default: ;
      endcase
    end
  end

`ifdef SEQ_DET_SCHED_RR_EN
  logic [PW-1:0] ptr_nxt;

  always_comb begin
    ptr_nxt = ptr;
    for (int i = 0; i < N; i++)
      if (owner[i]) ptr_nxt = (i == N - 1) ? '0 : PW'(i + 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                ptr <= '0;
    else if (state == DONE) ptr <= ptr_nxt;
  end
`else
  assign ptr = '0;
`endif

  assign bus.gnt     = (state == GRANT || state == SHIFT || state == DRAIN) ? owner : '0;
  assign bus.done    = (state == DONE) ? owner : '0;
  assign bus.hit_cnt = hit_q;
  assign bus.busy    = (state != IDLE);
  assign bus.det_rst = (state == IDLE || state == GRANT);
  assign bus.det_a   = (state == SHIFT) && frame[W-1];
endmodule

// File: tb/tb_seq_det_sched.sv
// Directed bench for seq_det_sched with a reference 1101 overlapping Moore detector.
// Round-robin expectations apply when SEQ_DET_SCHED_RR_EN is defined.
module tb_seq_det_sched;
  localparam int N = 4;
  localparam int W = 8;

  logic clk;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  seq_det_sched_if #(.N(N), .W(W)) bus ();

  seq_det_sched #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference detector: 0 idle, 1 "1", 2 "11", 3 "110", 4 "1101" (q=1)
  logic [2:0] ds;
  always_ff @(posedge clk) begin
    if (bus.det_rst) ds <= 3'd0;
    else case (ds)
      3'd0:    ds <= bus.det_a ? 3'd1 : 3'd0;
      3'd1:    ds <= bus.det_a ? 3'd2 : 3'd0;
      3'd2:    ds <= bus.det_a ? 3'd2 : 3'd3;
      3'd3:    ds <= bus.det_a ? 3'd4 : 3'd0;
      default: ds <= bus.det_a ? 3'd2 : 3'd0;
    endcase
  end
  assign bus.det_q = (ds == 3'd4);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Call from an IDLE cycle; returns in the IDLE cycle after DONE with req cleared.
  task automatic frame(input string tag, input logic [N-1:0] rq, input logic [N*W-1:0] data,
                       input logic [N-1:0] g, input logic [W-1:0] fr, input int hit,
                       input int drop_k);
    bus.req      = rq;
    bus.req_data = data;
    tick();
    chk({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
    chk({tag, ".drst"}, 32'(bus.det_rst), 32'd1);
    for (int i = 0; i < W; i++) begin
      tick();
      chk($sformatf("%s.a%0d", tag, i), 32'(bus.det_a), 32'(fr[W-1-i]));
      if (i == drop_k) begin
        bus.req      = '0;
        bus.req_data = ~data;
      end
    end
    tick();
    chk({tag, ".drain_a"}, 32'(bus.det_a), 32'd0);
    chk({tag, ".drain_gnt"}, 32'(bus.gnt), 32'(g));
    tick();
    chk({tag, ".done"}, 32'(bus.done), 32'(g));
    chk({tag, ".hit"}, 32'(bus.hit_cnt), 32'(hit));
    chk({tag, ".gnt0"}, 32'(bus.gnt), 32'd0);
    bus.req = '0;
    tick();
    chk({tag, ".hold"}, 32'(bus.hit_cnt), 32'(hit));
    chk({tag, ".idle"}, 32'(bus.busy), 32'd0);
    chk({tag, ".done0"}, 32'(bus.done), 32'd0);
  endtask

  task automatic idle_vals(input string tag);
    chk({tag, ".gnt"}, 32'(bus.gnt), 32'd0);
    chk({tag, ".done"}, 32'(bus.done), 32'd0);
    chk({tag, ".busy"}, 32'(bus.busy), 32'd0);
    chk({tag, ".a"}, 32'(bus.det_a), 32'd0);
    chk({tag, ".drst"}, 32'(bus.det_rst), 32'd1);
  endtask

  logic [N-1:0] eg [5];
  int           eh [5];

  initial begin
`ifdef SEQ_DET_SCHED_RR_EN
    eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    eh = '{2, 2, 1, 0, 2};
`else
    eg = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    eh = '{2, 2, 2, 2, 2};
`endif
    rst          = 1'b0;
    bus.req      = '0;
    bus.req_data = '0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    idle_vals("rst");
    chk("rst.hit", 32'(bus.hit_cnt), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      idle_vals($sformatf("idle%0d", i));
      chk($sformatf("idle%0d.hit", i), 32'(bus.hit_cnt), 32'd0);
    end

    frame("ovl",  4'b0001, 32'h0000_00DA, 4'b0001, 8'hDA, 2, -1);
    frame("last", 4'b0100, 32'h000D_0000, 4'b0100, 8'h0D, 1, -1);
    frame("zero", 4'b1000, 32'h00FF_FFFF, 4'b1000, 8'h00, 0, -1);
    frame("drop", 4'b0010, 32'h0000_6D00, 4'b0010, 8'h6D, 2, 3);

    // Reset during SHIFT k=4
    bus.req      = 4'b0001;
    bus.req_data = 32'h0000_00DA;
    repeat (6) tick();
    chk("mid.busy", 32'(bus.busy), 32'd1);
    rst     = 1'b1;
    bus.req = '0;
    #1;
    idle_vals("midrst");
    chk("midrst.hit", 32'(bus.hit_cnt), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("midrst.done%0d", i), 32'(bus.done), 32'd0);
    end
    rst = 1'b0;
    tick();
    frame("post", 4'b0001, 32'h0000_000D, 4'b0001, 8'h0D, 1, -1);

    // Continuous requests from all four after a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    bus.req      = 4'b1111;
    bus.req_data = 32'h000D_6DDA;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk($sformatf("rr%0d.gnt", g), 32'(bus.gnt), 32'(eg[g]));
      repeat (10) tick();
      chk($sformatf("rr%0d.done", g), 32'(bus.done), 32'(eg[g]));
      chk($sformatf("rr%0d.hit", g), 32'(bus.hit_cnt), 32'(eh[g]));
      tick();
    end
    bus.req = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
